// File: rtl/aes_pkg.sv
// Shared AES helpers: legal state widths, row shift offsets and the
// ShiftRows/InvShiftRows byte permutation. The permutation takes and returns
// a 256-bit container. Only the low 32*nb bits are used.
// Byte i of a state is at [8*(4*nb-1-i) +: 8], where i = 4*c + r.
package aes_pkg;

    localparam int unsigned NB_128 = 4;
    localparam int unsigned NB_192 = 6;
    localparam int unsigned NB_256 = 8;

    localparam int unsigned MAX_STATE_W = 32 * NB_256;

    // Occupancy of the output register and skid entry, encoded as {out_valid, sk_valid}.
    typedef enum logic [1:0] {
        OccEmpty = 2'b00,
        OccOne   = 2'b10,
        OccFull  = 2'b11
    } occ_e;

    // Rijndael row shift: {0,1,2,3} for Nb = 4/6, {0,1,3,4} for Nb = 8.
    function automatic int unsigned aes_shift_ofs(input int unsigned nb, input int unsigned r);
        if (nb == NB_256 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    function automatic logic [MAX_STATE_W-1:0] aes_rowperm(input logic [MAX_STATE_W-1:0] state,
                                                          input int unsigned nb,
                                                          input logic inv);
        logic [MAX_STATE_W-1:0] res;
        int unsigned            sh;
        int unsigned            src_c;
        res = '0;
        for (int unsigned c = 0; c < NB_256; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                if (c < nb) begin
                    sh    = aes_shift_ofs(nb, r);
                    // Adding nb before subtracting keeps the inverse index non-negative.
                    src_c = inv ? (c + nb - sh) % nb : (c + sh) % nb;
                    res[8*(4*nb-1-(4*c+r)) +: 8] = state[8*(4*nb-1-(4*src_c+r)) +: 8];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_rowperm_comb.sv
// Purely combinational ShiftRows (inv_i = 0) / InvShiftRows (inv_i = 1).
// It handles Nb columns of 4 rows.
//   state_i  32*NB  input state, column-major byte packing
//   inv_i    1      direction select
//   state_o  32*NB  permuted state, same packing
module aes_rowperm_comb
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [32*NB-1:0] state_i,
    input  logic             inv_i,
    output logic [32*NB-1:0] state_o
);

    logic [MAX_STATE_W-1:0] wide_in;
    logic [MAX_STATE_W-1:0] wide_out;

    assign wide_in  = MAX_STATE_W'(state_i);
    assign wide_out = aes_rowperm(wide_in, NB, inv_i);
    assign state_o  = wide_out[32*NB-1:0];

    // The container bits above the real state are always zero.
    if (NB < NB_256) begin : gen_unused_hi
        logic unused_hi;
        assign unused_hi = ^wide_out[MAX_STATE_W-1:32*NB];
    end

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// Registered, handshaked ShiftRows/InvShiftRows stage with a one-entry skid buffer.
// The direction is chosen per block. The stage carries a sideband tag and counts
// blocks leaving the output.
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     input handshake; in_ready comes straight from a flop
//   in_state/in_inv/in_tag  block, direction, sideband
//   out_valid/out_ready   output handshake; out_valid comes straight from a flop
//   out_state/out_tag     permuted block and its tag
//   blk_cnt               wrapping count of output transfers
module aes_shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_state,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_state,
    output logic [TAG_W-1:0]   out_tag,
    output logic [CNT_W-1:0]   blk_cnt
);

    localparam int unsigned W = 32 * NB;

    if (NB != NB_128 && NB != NB_192 && NB != NB_256) begin : gen_bad_nb
        $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0]     perm_state;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_state_q, out_state_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             sk_valid_q, sk_valid_d;
    logic [W-1:0]     sk_state_q, sk_state_d;
    logic [TAG_W-1:0] sk_tag_q, sk_tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_acc;
    logic             out_xfer;
    occ_e             occ;

    // Permute on the way in, so both storage slots hold finished data.
    aes_rowperm_comb #(
        .NB(NB)
    ) u_rowperm (
        .state_i(in_state),
        .inv_i  (in_inv),
        .state_o(perm_state)
    );

    assign in_ready  = ~sk_valid_q;
    assign in_acc    = in_valid & ~sk_valid_q;
    assign out_xfer  = out_valid_q & out_ready;
    assign occ       = occ_e'({out_valid_q, sk_valid_q});

    always_comb begin
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_tag_d   = out_tag_q;
        sk_valid_d  = sk_valid_q;
        sk_state_d  = sk_state_q;
        sk_tag_d    = sk_tag_q;
        cnt_d       = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;

        unique case (occ)
            OccEmpty: begin
                if (in_acc) begin
                    out_valid_d = 1'b1;
                    out_state_d = perm_state;
                    out_tag_d   = in_tag;
                end
            end
            OccOne: begin
                if (out_ready) begin
                    // A new block reloads the output directly; otherwise the output drains.
                    out_valid_d = in_acc;
                    if (in_acc) begin
                        out_state_d = perm_state;
                        out_tag_d   = in_tag;
                    end
                end else if (in_acc) begin
                    sk_valid_d = 1'b1;
                    sk_state_d = perm_state;
                    sk_tag_d   = in_tag;
                end
            end
            OccFull: begin
                // in_ready is low here, so only the skid entry can move up.
                if (out_ready) begin
                    out_state_d = sk_state_q;
                    out_tag_d   = sk_tag_q;
                    sk_valid_d  = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_tag_q   <= '0;
            sk_valid_q  <= 1'b0;
            sk_state_q  <= '0;
            sk_tag_q    <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_tag_q   <= out_tag_d;
            sk_valid_q  <= sk_valid_d;
            sk_state_q  <= sk_state_d;
            sk_tag_q    <= sk_tag_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_tag   = out_tag_q;
    assign blk_cnt   = cnt_q;

    a_skid_implies_out : assert property (@(posedge clk) disable iff (!rst_n)
        !(sk_valid_q && !out_valid_q));

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Bench for aes_shiftrows_pipe. It drives three instances with NB = 4, 6 and 8.
// The NB = 8 instance has a 4-bit counter. A queue-based model predicts occupancy,
// handshakes, output data, tags and the block count every cycle.
module tb_aes_shiftrows_pipe;

    typedef struct {
        logic [255:0] st;
        logic [255:0] orig;
        logic         inv;
        logic [3:0]   tag;
    } ent_t;

    localparam logic [255:0] T1_IN  = 256'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [255:0] T1_OUT = 256'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [255:0] T2_IN  = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] T2_INV = 256'h000d0a0704010e0b0805020f0c090603;
    localparam logic [255:0] T2_FWD = 256'h00050a0f04090e03080d02070c01060b;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv   [3];
    logic [255:0] ist  [3];
    logic         iinv [3];
    logic [3:0]   itag [3];
    logic         ordy [3];
    wire          ir   [3];
    wire          ov   [3];
    wire  [3:0]   ot   [3];
    wire  [255:0] ost  [3];
    wire  [15:0]  oc   [3];
    wire  [127:0] os4;
    wire  [191:0] os6;
    wire  [255:0] os8;
    wire  [15:0]  c4, c6;
    wire  [3:0]   c8;

    int           nbv [3] = '{4, 6, 8};
    int           n_checks = 0;
    int           n_pass = 0;
    ent_t         q [3][$];
    logic [15:0]  ecnt [3];

    always #5 clk = ~clk;

    assign ost[0] = {128'b0, os4};
    assign ost[1] = {64'b0, os6};
    assign ost[2] = os8;
    assign oc[0]  = c4;
    assign oc[1]  = c6;
    assign oc[2]  = {12'b0, c8};

    aes_shiftrows_pipe #(.NB(4), .TAG_W(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_state(ist[0][127:0]), .in_inv(iinv[0]), .in_tag(itag[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os4), .out_tag(ot[0]),
        .blk_cnt(c4)
    );

    aes_shiftrows_pipe #(.NB(6), .TAG_W(4), .CNT_W(16)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_state(ist[1][191:0]), .in_inv(iinv[1]), .in_tag(itag[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os6), .out_tag(ot[1]),
        .blk_cnt(c6)
    );

    aes_shiftrows_pipe #(.NB(8), .TAG_W(4), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_state(ist[2]), .in_inv(iinv[2]), .in_tag(itag[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os8), .out_tag(ot[2]),
        .blk_cnt(c8)
    );

    // Reference: unpack to a byte array, apply t[4c+r] = s[4*src_c + r], repack.
    function automatic logic [255:0] ref_perm(input logic [255:0] s, input int nb, input logic inv);
        logic [7:0]   b [32];
        logic [7:0]   t [32];
        int           sh [4];
        int           src;
        logic [255:0] res;
        sh[0] = 0;
        sh[1] = 1;
        sh[2] = (nb == 8) ? 3 : 2;
        sh[3] = (nb == 8) ? 4 : 3;
        for (int i = 0; i < 4 * nb; i++) b[i] = s[8*(4*nb-1-i) +: 8];
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
                t[4*c+r] = b[4*src+r];
            end
        end
        res = '0;
        for (int i = 0; i < 4 * nb; i++) res[8*(4*nb-1-i) +: 8] = t[i];
        return res;
    endfunction

    function automatic logic [255:0] rand_state(input int nb);
        logic [255:0] s;
        for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
        return s & ((256'd1 << (32 * nb)) - 256'd1);
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the block until it is accepted, with a bounded wait.
    task automatic send(input int k, input logic [255:0] st, input logic inv, input logic [3:0] tag);
        logic acc;
        int   n;
        iv[k] = 1'b1;
        ist[k] = st;
        iinv[k] = inv;
        itag[k] = tag;
        n = 0;
        do begin
            acc = ir[k];
            step();
            n++;
        end while (!acc && n < 100);
        iv[k] = 1'b0;
        n_checks++;
        if (acc) n_pass++;
        else $display("FAIL send_timeout dut%0d: accepted %0b required 1", k, acc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Per-cycle compare against the queue model: occupancy gives out_valid and in_ready.
    // The queue head gives out_state and out_tag.
    initial forever begin
        ent_t e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                q[k].delete();
                ecnt[k] = '0;
            end else begin
                chk($sformatf("blk_cnt%0d", k), 256'(oc[k]), 256'(ecnt[k]));
                chk($sformatf("out_valid%0d", k), 256'(ov[k]), 256'(q[k].size() != 0));
                chk($sformatf("in_ready%0d", k), 256'(ir[k]), 256'(q[k].size() < 2));
                if (ov[k] && q[k].size() != 0) begin
                    chk($sformatf("out_state%0d", k), ost[k], q[k][0].st);
                    chk($sformatf("out_tag%0d", k), 256'(ot[k]), 256'(q[k][0].tag));
                    chk($sformatf("roundtrip%0d", k), ref_perm(ost[k], nbv[k], !q[k][0].inv),
                        q[k][0].orig);
                    if (ordy[k]) begin
                        e = q[k].pop_front();
                        ecnt[k] = (ecnt[k] + 16'd1) & ((k == 2) ? 16'h000f : 16'hffff);
                    end
                end
                if (iv[k] && ir[k]) begin
                    e.orig = ist[k];
                    e.inv  = iinv[k];
                    e.tag  = itag[k];
                    e.st   = ref_perm(ist[k], nbv[k], iinv[k]);
                    q[k].push_back(e);
                end
            end
        end
    end

    initial begin
        int   sent [3];
        logic acc [3];
        int   cycles;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0;
            ist[k] = '0;
            iinv[k] = 1'b0;
            itag[k] = '0;
            ordy[k] = 1'b1;
            sent[k] = 0;
        end
        do_reset();

        // Reset state.
        chk("rst_out_state", ost[0], 256'd0);
        chk("rst_out_tag", 256'(ot[0]), 256'd0);

        // Model pinned by hand-computed vectors.
        chk("model_t1", ref_perm(T1_IN, 4, 1'b0), T1_OUT);
        chk("model_t2_inv", ref_perm(T2_IN, 4, 1'b1), T2_INV);
        chk("model_t2_fwd", ref_perm(T2_IN, 4, 1'b0), T2_FWD);

        // T1/T2: result visible the cycle after acceptance.
        send(0, T1_IN, 1'b0, 4'h5);
        chk("t1_out", ost[0], T1_OUT);
        chk("t1_tag", 256'(ot[0]), 256'h5);
        send(0, T2_IN, 1'b1, 4'h6);
        chk("t2_inv_out", ost[0], T2_INV);
        send(0, T2_IN, 1'b0, 4'h7);
        chk("t2_fwd_out", ost[0], T2_FWD);
        step();

        // T3: back-to-back, one per cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(0, rand_state(4), 1'(i), 4'(i));
            chk("t3_valid", 256'(ov[0]), 256'd1);
            chk("t3_tag", 256'(ot[0]), 256'(i));
        end
        step();
        chk("t3_blk_cnt", 256'(oc[0]), 256'd8);

        // T4: backpressure fills output + skid, then drains in order.
        ordy[0] = 1'b0;
        send(0, rand_state(4), 1'b0, 4'h1);
        send(0, rand_state(4), 1'b1, 4'h2);
        chk("t4_full_ready", 256'(ir[0]), 256'd0);
        iv[0] = 1'b1;
        ist[0] = rand_state(4);
        iinv[0] = 1'b0;
        itag[0] = 4'h3;
        step();
        chk("t4_stall_ready", 256'(ir[0]), 256'd0);
        chk("t4_stall_tag", 256'(ot[0]), 256'h1);
        ordy[0] = 1'b1;
        step();
        chk("t4_second_tag", 256'(ot[0]), 256'h2);
        step();
        chk("t4_third_tag", 256'(ot[0]), 256'h3);
        iv[0] = 1'b0;
        step();

        // T5: asynchronous reset while full.
        ordy[0] = 1'b0;
        send(0, rand_state(4), 1'b0, 4'h4);
        send(0, rand_state(4), 1'b1, 4'h5);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 256'(ov[0]), 256'd0);
        chk("t5_in_ready", 256'(ir[0]), 256'd1);
        chk("t5_blk_cnt", 256'(oc[0]), 256'd0);
        chk("t5_out_state", ost[0], 256'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ordy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_stale", 256'(ov[0]), 256'd0);
        end

        // T6: random traffic on NB = 6 and NB = 8 with random backpressure.
        cycles = 0;
        while ((sent[1] < 1000 || sent[2] < 1000) && cycles < 20000) begin
            for (int k = 1; k < 3; k++) begin
                acc[k] = iv[k] && ir[k];
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            step();
            cycles++;
            for (int k = 1; k < 3; k++) begin
                if (acc[k]) sent[k]++;
                if (acc[k] || !iv[k]) begin
                    if (sent[k] < 1000 && $urandom_range(0, 4) != 0) begin
                        iv[k] = 1'b1;
                        ist[k] = rand_state(nbv[k]);
                        iinv[k] = 1'($urandom);
                        itag[k] = 4'($urandom);
                    end else begin
                        iv[k] = 1'b0;
                    end
                end
            end
        end
        chk("t6_sent6", 256'(sent[1]), 256'd1000);
        chk("t6_sent8", 256'(sent[2]), 256'd1000);
        for (int k = 1; k < 3; k++) begin
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        repeat (4) step();
        chk("t6_drained6", 256'(q[1].size()), 256'd0);
        chk("t6_drained8", 256'(q[2].size()), 256'd0);

        // Counter wrap on the 4-bit instance: 17 transfers -> 1.
        do_reset();
        for (int i = 0; i < 17; i++) send(2, rand_state(8), 1'($urandom), 4'(i));
        step();
        chk("cnt_wrap", 256'(oc[2]), 256'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
